pe_bus_arb: RTL and testbench

PE_BUS_ARB -- requirements
Module: pe_bus_arb

---
 rtl/pe_bus_arb.sv | 140 ++++++++++++++
 tb/tb_pe_bus_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_bus_arb.sv
// rtl/pe_bus_arb.sv - round-robin arbiter granting NUM_PE processing elements one shared bus
// Each grant runs one bus transaction, bounded by TIMEOUT busy cycles, then pulses done_o.
module pe_bus_arb #(
  parameter int NUM_PE    = 4,
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 255,
  localparam int OW       = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_PE-1:0]        req_i,
  input  logic [NUM_PE*AD_LEN-1:0] ad_i,
  output logic [NUM_PE-1:0]        done_o,
  output logic                     err_o,
  output logic [BUS_WIDTH-1:0]     data_o,
  output logic [OW-1:0]            owner_o,
  output logic                     bus_req_o,
  output logic [AD_LEN-1:0]        bus_ad_o,
  input  logic                     bus_ack_i,
  input  logic [BUS_WIDTH-1:0]     bus_data_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic [AD_LEN-1:0]     bus_ad_q, bus_ad_d;
  logic [NUM_PE-1:0]     done_q, done_d;
  logic                  err_q, err_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_q, last_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  found;
  logic [OW-1:0]         grant_idx;
  logic [AD_LEN-1:0]     ad_sel;

  // Rotating priority: the PE after the last owner is searched first.
  always_comb begin
    int j;
    found     = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int i = 1; i <= NUM_PE; i++) begin
      j = int'(last_q) + i;
      if (j >= NUM_PE) j = j - NUM_PE;
      if (!found && req_i[OW'(j)]) begin
        found     = 1'b1;
        grant_idx = OW'(j);
      end
    end
  end

  always_comb begin
    ad_sel = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (grant_idx == OW'(k)) ad_sel = ad_i[k*AD_LEN +: AD_LEN];
    end
  end

  always_comb begin
    state_d   = state_q;
    bus_req_d = bus_req_q;
    bus_ad_d  = bus_ad_q;
    done_d    = '0;
    err_d     = err_q;
    data_d    = data_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = BUSY;
          bus_req_d = 1'b1;
          bus_ad_d  = ad_sel;
          owner_d   = grant_idx;
          cnt_d     = '0;
        end
      end
      BUSY: begin
        // An ack in the last counted cycle takes precedence over the timeout.
        if (bus_ack_i) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          data_d    = bus_data_i;
          err_d     = 1'b0;
          done_d    = NUM_PE'(1) << owner_q;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          data_d    = '0;
          err_d     = 1'b1;
          done_d    = NUM_PE'(1) << owner_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      bus_req_q <= 1'b0;
      bus_ad_q  <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
      owner_q   <= '0;
      last_q    <= OW'(NUM_PE - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bus_req_q <= bus_req_d;
      bus_ad_q  <= bus_ad_d;
      done_q    <= done_d;
      err_q     <= err_d;
      data_q    <= data_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign done_o    = done_q;
  assign err_o     = err_q;
  assign data_o    = data_q;
  assign owner_o   = owner_q;
  assign bus_req_o = bus_req_q;
  assign bus_ad_o  = bus_ad_q;

endmodule

// File: tb/tb_pe_bus_arb.sv
// tb/tb_pe_bus_arb.sv - scoreboard bench for pe_bus_arb with a scripted bus responder
module tb_pe_bus_arb;

  localparam int NUM_PE = 4;
  localparam int AD_LEN = 32;
  localparam int BW     = 32;

  logic                     clk_i = 1'b0;
  logic                     reset_i;
  logic [NUM_PE-1:0]        req_i;
  logic [NUM_PE*AD_LEN-1:0] ad_i;
  logic [NUM_PE-1:0]        done_o;
  logic                     err_o;
  logic [BW-1:0]            data_o;
  logic [1:0]               owner_o;
  logic                     bus_req_o;
  logic [AD_LEN-1:0]        bus_ad_o;
  logic                     bus_ack_i;
  logic [BW-1:0]            bus_data_i;

  pe_bus_arb #(.NUM_PE(NUM_PE), .AD_LEN(AD_LEN), .BUS_WIDTH(BW), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .ad_i(ad_i),
    .done_o(done_o), .err_o(err_o), .data_o(data_o), .owner_o(owner_o),
    .bus_req_o(bus_req_o), .bus_ad_o(bus_ad_o), .bus_ack_i(bus_ack_i),
    .bus_data_i(bus_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          owner;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          blen;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_delay = -1;
  logic [31:0] resp_data = '0;
  logic        stray = 1'b0;
  int          bcnt = 0;
  logic [31:0] first_ad = '0;
  int          blen = 0;
  logic        ad_moved = 1'b0;
  logic        prev_req = 1'b0;
  logic [3:0]  prev_done = '0;
  int          n;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int owner, input logic [31:0] addr, input logic [31:0] data,
                      input logic err, input int bl);
    exp_t x;
    x.owner = owner; x.addr = addr; x.data = data; x.err = err; x.blen = bl;
    sb.push_back(x);
  endtask

  task automatic set_addrs();
    for (int k = 0; k < NUM_PE; k++) ad_i[k*AD_LEN +: AD_LEN] = 32'h0F00 + 32'h100 * k;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      cyc++;
      if (done_o != '0) return;
    end
    check("wait_done_timeout", 1, 0);
  endtask

  task automatic gap();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  // Bus slave: acks on the ack_delay-th busy cycle (0-based); -1 never acks.
  initial begin
    bus_ack_i  = 1'b0;
    bus_data_i = 32'h5A5A5A5A;
    forever begin
      @(posedge clk_i);
      #1;
      if (bus_req_o) begin
        bus_ack_i = (ack_delay >= 0) && (bcnt == ack_delay);
        bcnt++;
      end else begin
        bus_ack_i = stray;
        bcnt = 0;
      end
      bus_data_i = bus_ack_i ? resp_data : 32'h5A5A5A5A;
    end
  end

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (bus_req_o) begin
        if (!prev_req) begin
          first_ad = bus_ad_o;
          blen     = 0;
          ad_moved = 1'b0;
        end else if (bus_ad_o !== first_ad) begin
          ad_moved = 1'b1;
        end
        blen++;
      end
      if (prev_done != '0) check("done_one_cycle", done_o, 0);
      if (done_o != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done_o, 0);
        end else begin
          e = sb.pop_front();
          check("done_o", done_o, 4'b0001 << e.owner);
          check("owner_o", owner_o, e.owner);
          check("err_o", err_o, e.err);
          check("data_o", data_o, e.data);
          check("bus_ad", first_ad, e.addr);
          check("bus_ad_stable", ad_moved, 0);
          check("busy_len", blen, e.blen);
          check("bus_req_in_done", bus_req_o, 0);
        end
      end
    end
    prev_req  = bus_req_o;
    prev_done = done_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    req_i   = '0;
    set_addrs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_bus_req", bus_req_o, 0);
    check("rst_bus_ad", bus_ad_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_data", data_o, 0);
    check("rst_owner", owner_o, 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    gap();

    // Single request, ack on 4th busy cycle
    ack_delay = 3; resp_data = 32'hDEADBEEF;
    push(1, 32'h1000, 32'hDEADBEEF, 1'b0, 4);
    req_i = 4'b0010;
    wait_done(n);
    req_i = '0;
    check("lat_single", n - 1, 5);
    gap();

    // Minimum latency
    ack_delay = 0; resp_data = 32'h00001234;
    push(2, 32'h1100, 32'h00001234, 1'b0, 1);
    req_i = 4'b0100;
    wait_done(n);
    req_i = '0;
    check("lat_min", n - 1, 2);
    gap();

    // Timeout with no ack
    ack_delay = -1; resp_data = 32'h77777777;
    push(0, 32'h0F00, 32'h0, 1'b1, 4);
    req_i = 4'b0001;
    wait_done(n);
    req_i = '0;
    check("lat_timeout", n - 1, 5);
    gap();

    // Ack in the final counted cycle beats timeout
    ack_delay = 3; resp_data = 32'hCAFEF00D;
    push(0, 32'h0F00, 32'hCAFEF00D, 1'b0, 4);
    req_i = 4'b0001;
    wait_done(n);
    req_i = '0;
    gap();

    // Stray ack in IDLE
    resp_data = 32'h11111111; stray = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("stray_no_req", bus_req_o, 0);
      check("stray_no_done", done_o, 0);
    end
    check("stray_data_hold", data_o, 32'hCAFEF00D);
    stray = 1'b0;
    gap();

    // Withdrawn request and address change during BUSY
    ack_delay = 2; resp_data = 32'h33333333;
    push(3, 32'h1200, 32'h33333333, 1'b0, 3);
    req_i = 4'b1000;
    repeat (2) @(posedge clk_i);
    #1;
    req_i = '0;
    ad_i[3*AD_LEN +: AD_LEN] = 32'h0000BAD0;
    wait_done(n);
    set_addrs();
    gap();

    // Reset mid-BUSY aborts silently
    ack_delay = -1;
    req_i = 4'b0100;
    repeat (2) @(posedge clk_i);
    #1;
    check("pre_reset_busy", bus_req_o, 1);
    reset_i = 1'b1;
    req_i   = '0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check("reset_abort_req", bus_req_o, 0);
    check("reset_abort_done", done_o, 0);

    // Round robin from reset: 0,1,2,3,0
    ack_delay = 1; resp_data = 32'h0BADF00D;
    push(0, 32'h0F00, 32'h0BADF00D, 1'b0, 2);
    push(1, 32'h1000, 32'h0BADF00D, 1'b0, 2);
    push(2, 32'h1100, 32'h0BADF00D, 1'b0, 2);
    push(3, 32'h1200, 32'h0BADF00D, 1'b0, 2);
    push(0, 32'h0F00, 32'h0BADF00D, 1'b0, 2);
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) wait_done(n);
    req_i = '0;
    gap();
    repeat (4) @(negedge clk_i);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
